// File: rtl/matvec_sched.sv
// matvec_sched: sequences y = M*x one row at a time over a single shared vecvec dot-product unit
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           job request, accepted only when idle; latches mat and vec
//   mat, vec        operand matrix (row r at [r*VECTOR_SIZE*DATA_WIDTH +: ...]) and vector
//   busy, done      job in progress; one-cycle completion pulse
//   error           sticky per-row timeout flag, cleared by rst or the next accepted start
//   result          y[r] at [r*DATA_WIDTH +: DATA_WIDTH], held until overwritten
//   dot_*           handshake and operands for the attached vecvec unit
module matvec_sched #(
    parameter int DATA_WIDTH  = 32,
    parameter int BIN_POS     = 16,
    parameter int VECTOR_SIZE = 4,
    parameter int ROWS        = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [ROWS*VECTOR_SIZE*DATA_WIDTH-1:0]  mat,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0]       vec,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error,
    output logic [ROWS*DATA_WIDTH-1:0]              result,
    output logic                                    dot_rst,
    input  logic                                    dot_ready,
    input  logic                                    dot_complete,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0]       dot_vec_a,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0]       dot_vec_b,
    input  logic [DATA_WIDTH-1:0]                   dot_result
);
    localparam int VW = VECTOR_SIZE * DATA_WIDTH;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [ROWS*VW-1:0]   mat_q, mat_d;
    logic [RW-1:0]        row_q, row_d, row_nxt;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 busy_q, busy_d, done_q, done_d, error_q, error_d, dot_rst_q, dot_rst_d;
    logic [ROWS*DATA_WIDTH-1:0] result_q, result_d;
    logic [VW-1:0]        dot_vec_a_q, dot_vec_a_d, dot_vec_b_q, dot_vec_b_d;

    // The binary point only describes the attached unit's number format; nothing is computed here.
    logic unused_bin_pos;
    assign unused_bin_pos = ^BIN_POS;

    assign row_nxt = row_q + RW'(1);

    always_comb begin
        state_d     = state_q;
        mat_d       = mat_q;
        row_d       = row_q;
        timer_d     = timer_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        result_d    = result_q;
        dot_rst_d   = dot_rst_q;
        dot_vec_a_d = dot_vec_a_q;
        dot_vec_b_d = dot_vec_b_q;
        case (state_q)
            IDLE: begin
                dot_rst_d = 1'b1;
                if (start) begin
                    mat_d       = mat;
                    dot_vec_b_d = vec;
                    dot_vec_a_d = mat[VW-1:0];
                    error_d     = 1'b0;
                    row_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (dot_ready) begin
                    dot_rst_d = 1'b0;
                    timer_d   = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                timer_d = timer_q + TW'(1);
                if (dot_complete) begin
                    result_d[int'(row_q)*DATA_WIDTH +: DATA_WIDTH] = dot_result;
                    dot_rst_d = 1'b1;
                    if (row_q == RW'(ROWS - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        // Present the next row while the unit is held in reset during LOAD.
                        row_d       = row_nxt;
                        dot_vec_a_d = mat_q[int'(row_nxt)*VW +: VW];
                        state_d     = LOAD;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    dot_rst_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mat_q       <= '0;
            row_q       <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            result_q    <= '0;
            dot_rst_q   <= 1'b1;
            dot_vec_a_q <= '0;
            dot_vec_b_q <= '0;
        end else begin
            state_q     <= state_d;
            mat_q       <= mat_d;
            row_q       <= row_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            result_q    <= result_d;
            dot_rst_q   <= dot_rst_d;
            dot_vec_a_q <= dot_vec_a_d;
            dot_vec_b_q <= dot_vec_b_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign result    = result_q;
    assign dot_rst   = dot_rst_q;
    assign dot_vec_a = dot_vec_a_q;
    assign dot_vec_b = dot_vec_b_q;
endmodule

// File: tb/tb_matvec_sched.sv
// tb_matvec_sched: self-checking bench for matvec_sched with a stub fixed-point dot unit
module tb_matvec_sched;
    localparam int DW = 32, VS = 4, ROWS = 4, TO = 16, VW = VS * DW;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [ROWS*VW-1:0] mat = '0;
    logic [VW-1:0] vec = '0;
    logic busy, done, error, dot_rst, dot_ready, dot_complete;
    logic [ROWS*DW-1:0] result;
    logic [VW-1:0] dot_vec_a, dot_vec_b;
    logic [DW-1:0] dot_result;

    int n_chk = 0, n_fail = 0, cyc = 0;

    matvec_sched #(.DATA_WIDTH(DW), .BIN_POS(16), .VECTOR_SIZE(VS), .ROWS(ROWS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mat(mat), .vec(vec),
        .busy(busy), .done(done), .error(error), .result(result),
        .dot_rst(dot_rst), .dot_ready(dot_ready), .dot_complete(dot_complete),
        .dot_vec_a(dot_vec_a), .dot_vec_b(dot_vec_b), .dot_result(dot_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-point dot product, Q(DW-16).16: exact sum of products, then rescale.
    function automatic logic [DW-1:0] dotf(input logic [VW-1:0] a, input logic [VW-1:0] b);
        longint s = 0;
        for (int i = 0; i < VS; i++)
            s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
        return DW'(s >>> 16);
    endfunction

    function automatic logic [VW-1:0] mrow(input logic [ROWS*VW-1:0] m, input int r);
        return m[r*VW +: VW];
    endfunction

    // Stub dot unit: complete rises after stub_lat edges sampled with rst low; 0 = never.
    int stub_lat = 2, st_cnt = 0;
    logic st_cmp = 1'b0, stub_ready = 1'b1;
    always @(posedge clk) begin
        if (dot_rst) begin
            st_cnt <= 0;
            st_cmp <= 1'b0;
        end else if (!st_cmp) begin
            st_cnt <= st_cnt + 1;
            st_cmp <= (stub_lat != 0) && (st_cnt + 1 == stub_lat);
        end
    end
    assign dot_complete = st_cmp;
    assign dot_ready    = stub_ready;
    assign dot_result   = dotf(dot_vec_a, dot_vec_b);

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: expected operands/results of the current job and its closed-form timeline.
    logic [ROWS*VW-1:0] exp_mat;
    logic [VW-1:0] exp_vec;
    logic [ROWS*DW-1:0] exp_res;
    bit job_on = 1'b0;
    int job_k = 0, job_lat = 0, rises = 0, per = 0, last = 0, cur_row = 0;
    bit ld_phase;
    logic prev_rst = 1'b1;

    // With ready high, each row is one LOAD cycle (dot_rst high) followed by L+1 RUN cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (job_on) begin
            job_k++;
            per  = job_lat + 2;
            last = ROWS * per;
            if (prev_rst === 1'b0 && dot_rst === 1'b1) rises++;
            if (job_k <= last) begin
                cur_row  = (job_k - 1) / per;
                ld_phase = ((job_k - 1) % per) == 0;
                check("busy", busy, 1);
                check("done_early", done, 0);
                check("error_in_job", error, 0);
                check("dot_rst_phase", dot_rst, ld_phase);
                check("dot_vec_a_row", dot_vec_a, mrow(exp_mat, cur_row));
                check("dot_vec_b", dot_vec_b, exp_vec);
            end else if (job_k == last + 1) begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                check("error_at_done", error, 0);
                check("dot_rst_at_done", dot_rst, 1);
                check("result", result, exp_res);
                check("dot_rst_rises", rises, ROWS);
            end else begin
                check("done_one_cycle", done, 0);
                check("busy_after_done", busy, 0);
                job_on = 1'b0;
            end
        end
        prev_rst = dot_rst;
    end

    task automatic load_job(input logic [ROWS*VW-1:0] m, input logic [VW-1:0] v);
        mat = m;
        vec = v;
        exp_mat = m;
        exp_vec = v;
        for (int r = 0; r < ROWS; r++) exp_res[r*DW +: DW] = dotf(m[r*VW +: VW], v);
    endtask

    // Run one regular job; dup != 0 pulses start again at that cycle of the job.
    // Inputs are scrambled while busy to show the latched copies are used.
    task automatic run_job(input int lat, input int dup);
        stub_lat   = lat;
        job_lat    = lat;
        stub_ready = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        job_k  = 0;
        rises  = 0;
        job_on = 1'b1;
        for (int t = 0; t < 1000 && job_on; t++) begin
            @(negedge clk);
            start = (dup != 0 && job_k == dup);
            for (int i = 0; i < ROWS * VS; i++) mat[i*DW +: DW] = $urandom;
            for (int i = 0; i < VS; i++) vec[i*DW +: DW] = $urandom;
        end
        start = 1'b0;
        if (job_on) begin
            n_chk++;
            n_fail++;
            $display("FAIL job_timeout: job still running after 1000 cycles, required done");
            job_on = 1'b0;
        end
    endtask

    logic [ROWS*VW-1:0] m;
    logic [VW-1:0] v;
    logic [ROWS*DW-1:0] held;
    int cnt, c0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_result", result, 0);
        check("rst_dot_rst", dot_rst, 1);
        check("rst_vec_a", dot_vec_a, 0);
        check("rst_vec_b", dot_vec_b, 0);
        rst = 1'b0;

        // Identity matrix times [1,2,3,4]
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            m[r*VW + r*DW +: DW] = 32'h0001_0000;
            v[r*DW +: DW] = DW'((r + 1) << 16);
        end
        load_job(m, v);
        run_job(2, 0);
        check("identity_result", result, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000});

        // 1.5 * 2.0 summed over four elements
        for (int i = 0; i < ROWS * VS; i++) m[i*DW +: DW] = 32'h0001_8000;
        for (int i = 0; i < VS; i++) v[i*DW +: DW] = 32'h0002_0000;
        load_job(m, v);
        run_job(3, 0);
        check("scaled_result", result, {4{32'h000C_0000}});

        // -1.0 rows, start pulsed again mid-job
        for (int i = 0; i < ROWS * VS; i++) m[i*DW +: DW] = 32'hFFFF_0000;
        for (int i = 0; i < VS; i++) v[i*DW +: DW] = 32'h0001_0000;
        load_job(m, v);
        run_job(1, 5);
        check("negative_result", result, {4{32'hFFFC_0000}});

        // ready held low for the first LOAD cycle adds one cycle to the job
        for (int i = 0; i < ROWS * VS; i++) m[i*DW +: DW] = $urandom;
        load_job(m, v);
        stub_lat = 2;
        stub_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("wait_ready_dot_rst", dot_rst, 1);
        check("wait_ready_busy", busy, 1);
        stub_ready = 1'b1;
        for (int t = 0; t < 500 && !done; t++) @(negedge clk);
        check("ready_delay_latency", cyc - c0, ROWS * (2 + 2) + 2);
        check("ready_delay_result", result, exp_res);

        // Dot unit never completes: timeout after TO RUN cycles
        held = result;
        for (int i = 0; i < ROWS * VS; i++) m[i*DW +: DW] = $urandom;
        load_job(m, v);
        stub_lat = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int t = 0; t < 200 && !error; t++) begin
            @(posedge clk);
            #1;
            if (!dot_rst) cnt++;
        end
        check("timeout_run_cycles", cnt, TO);
        check("timeout_error", error, 1);
        check("timeout_busy", busy, 0);
        check("timeout_dot_rst", dot_rst, 1);
        check("timeout_done", done, 0);
        check("timeout_result_kept", result, held);
        repeat (2) @(negedge clk);
        check("error_sticky", error, 1);
        for (int i = 0; i < ROWS * VS; i++) m[i*DW +: DW] = $urandom;
        load_job(m, v);
        run_job(2, 0);

        // Reset during RUN of row 2
        for (int i = 0; i < ROWS * VS; i++) m[i*DW +: DW] = $urandom;
        load_job(m, v);
        stub_lat = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("abort_in_run", dot_rst, 0);
        check("abort_row2", dot_vec_a, mrow(exp_mat, 2));
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_dot_rst", dot_rst, 1);
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        check("abort_error", error, 0);
        check("abort_vec_a", dot_vec_a, 0);
        rst = 1'b0;
        for (int i = 0; i < ROWS * VS; i++) m[i*DW +: DW] = $urandom;
        load_job(m, v);
        run_job(3, 0);

        // Random fixed-point jobs with varying dot-unit latency
        for (int j = 0; j < 100; j++) begin
            for (int i = 0; i < ROWS * VS; i++) m[i*DW +: DW] = $urandom;
            for (int i = 0; i < VS; i++) v[i*DW +: DW] = $urandom;
            load_job(m, v);
            run_job(int'($urandom_range(1, 8)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
